// File: rtl/alu_checker_if.sv
// Command and response handshake bundle between a command source and alu_checker.
// The command source drives the master side; the checker is the slave.
interface alu_checker_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [1:0]        in_sel;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [DATA_W-1:0] rsp_exp_result;
    logic              rsp_carry;
    logic              rsp_exp_carry;
    logic              rsp_mismatch;

    modport master (
        output in_valid, in_a, in_b, in_sel, rsp_ready,
        input  in_ready, rsp_valid, rsp_result, rsp_exp_result,
        input  rsp_carry, rsp_exp_carry, rsp_mismatch
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, rsp_ready,
        output in_ready, rsp_valid, rsp_result, rsp_exp_result,
        output rsp_carry, rsp_exp_carry, rsp_mismatch
    );
endinterface

// File: rtl/alu_checker.sv
// Drives a 4-bit ALU, waits SETTLE cycles, compares Result/Carry against a
// golden model and reports each op over a response handshake with statistics.
module alu_checker #(
    parameter int DATA_W = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_checker_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              clear,
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LOAD = 4'(SETTLE - 1);

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] exp_res_q, exp_res_d;
    logic              exp_carry_q, exp_carry_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              mism_q, mism_d;
    logic [CNT_W-1:0]  op_q, op_d, err_q, err_d;
    logic              flag_q, flag_d;

    logic [DATA_W:0]   sum, diff, golden;
    logic              accept, capture, mism;

    always_comb begin
        sum  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        // Borrow lands in the extra top bit of the unsigned difference
        diff = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        unique case (bus.in_sel)
            2'b00:   golden = sum;
            2'b01:   golden = diff;
            2'b10:   golden = {1'b0, bus.in_a & bus.in_b};
            default: golden = {1'b0, bus.in_a | bus.in_b};
        endcase
    end

    assign accept  = (state_q == S_IDLE) && in_ready_q && bus.in_valid;
    assign capture = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mism    = (alu_result != exp_res_q) || (alu_carry != exp_carry_q);

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        exp_res_d   = exp_res_q;
        exp_carry_d = exp_carry_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_carry_d = rsp_carry_q;
        mism_d      = mism_q;
        op_d        = op_q;
        err_d       = err_q;
        flag_d      = flag_q;

        unique case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    in_ready_d  = 1'b0;
                    a_d         = bus.in_a;
                    b_d         = bus.in_b;
                    sel_d       = bus.in_sel;
                    exp_res_d   = golden[DATA_W-1:0];
                    exp_carry_d = golden[DATA_W];
                    cnt_d       = LOAD;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    rsp_res_d   = alu_result;
                    rsp_carry_d = alu_carry;
                    mism_d      = mism;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        // Clear wins over a same-cycle capture; the response keeps its mismatch
        if (clear) begin
            op_d   = '0;
            err_d  = '0;
            flag_d = 1'b0;
        end else if (capture) begin
            if (op_q != '1) op_d = op_q + CNT_W'(1);
            if (mism) begin
                if (err_q != '1) err_d = err_q + CNT_W'(1);
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            exp_res_q   <= '0;
            exp_carry_q <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_carry_q <= 1'b0;
            mism_q      <= 1'b0;
            op_q        <= '0;
            err_q       <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            exp_res_q   <= exp_res_d;
            exp_carry_q <= exp_carry_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_carry_q <= rsp_carry_d;
            mism_q      <= mism_d;
            op_q        <= op_d;
            err_q       <= err_d;
            flag_q      <= flag_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_result     = rsp_res_q;
    assign bus.rsp_exp_result = exp_res_q;
    assign bus.rsp_carry      = rsp_carry_q;
    assign bus.rsp_exp_carry  = exp_carry_q;
    assign bus.rsp_mismatch   = mism_q;

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign op_count  = op_q;
    assign err_count = err_q;
    assign err_flag  = flag_q;

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench: three checkers (SETTLE=1, SETTLE=3, CNT_W=2) each driving
// a behavioural ALU whose Result bit 0 can be forced high.
module tb_alu_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       rr = 1'b1;
    logic [2:0] vld = 3'b000;
    logic [3:0] a_r = '0, b_r = '0;
    logic [1:0] s_r = '0;
    logic       f1 = 1'b0, f3 = 1'b0, fs = 1'b0;

    int errs = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    alu_checker_if #(.DATA_W(4)) if1 ();
    alu_checker_if #(.DATA_W(4)) if3 ();
    alu_checker_if #(.DATA_W(4)) ifs ();

    assign if1.in_valid = vld[0];
    assign if3.in_valid = vld[1];
    assign ifs.in_valid = vld[2];
    assign {if1.in_a, if1.in_b, if1.in_sel, if1.rsp_ready} = {a_r, b_r, s_r, rr};
    assign {if3.in_a, if3.in_b, if3.in_sel, if3.rsp_ready} = {a_r, b_r, s_r, rr};
    assign {ifs.in_a, ifs.in_b, ifs.in_sel, ifs.rsp_ready} = {a_r, b_r, s_r, rr};

    logic [3:0] a1, b1, r1, a3, b3, r3, as_, bs, rs;
    logic [1:0] s1, s3, ss;
    logic       c1, c3, cs, fl1, fl3, fls;
    logic [7:0] op1, er1, op3, er3;
    logic [1:0] ops, ers;
    logic [4:0] m1, m3, ms;

    function automatic logic [4:0] alu_m(logic [3:0] a, logic [3:0] b, logic [1:0] s);
        case (s)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign m1 = alu_m(a1, b1, s1);
    assign m3 = alu_m(a3, b3, s3);
    assign ms = alu_m(as_, bs, ss);
    assign r1 = m1[3:0] | {3'b000, f1};
    assign r3 = m3[3:0] | {3'b000, f3};
    assign rs = ms[3:0] | {3'b000, fs};
    assign c1 = m1[4];
    assign c3 = m3[4];
    assign cs = ms[4];

    alu_checker #(.DATA_W(4), .SETTLE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus(if1),
        .alu_a(a1), .alu_b(b1), .alu_sel(s1),
        .alu_result(r1), .alu_carry(c1), .clear(clear),
        .op_count(op1), .err_count(er1), .err_flag(fl1)
    );

    alu_checker #(.DATA_W(4), .SETTLE(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .bus(if3),
        .alu_a(a3), .alu_b(b3), .alu_sel(s3),
        .alu_result(r3), .alu_carry(c3), .clear(clear),
        .op_count(op3), .err_count(er3), .err_flag(fl3)
    );

    alu_checker #(.DATA_W(4), .SETTLE(1), .CNT_W(2)) duts (
        .clk(clk), .rst(rst), .bus(ifs),
        .alu_a(as_), .alu_b(bs), .alu_sel(ss),
        .alu_result(rs), .alu_carry(cs), .clear(clear),
        .op_count(ops), .err_count(ers), .err_flag(fls)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rv(input int d);
        case (d)
            0:       return if1.rsp_valid;
            1:       return if3.rsp_valid;
            default: return ifs.rsp_valid;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Latency counts rising edges from acceptance to rsp_valid being seen
    task automatic issue(input int d, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s, output int l);
        a_r = a;
        b_r = b;
        s_r = s;
        vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
        l = 0;
        while (!rv(d) && l < 20) begin
            @(negedge clk);
            l++;
        end
        chk("rsp_timeout", {31'd0, rv(d)}, 1);
    endtask

    initial begin
        tick(2);
        chk("rst_in_ready", if1.in_ready, 0);
        chk("rst_rsp_valid", if1.rsp_valid, 0);
        chk("rst_op_count", op1, 0);
        chk("rst_alu_a", a1, 0);
        rst = 1'b0;
        tick(1);
        chk("rel_in_ready", if1.in_ready, 1);

        issue(0, 4'd3, 4'd5, 2'b00, lat);
        chk("add1_lat", lat, 1);
        chk("add1_res", if1.rsp_result, 4'd8);
        chk("add1_c", if1.rsp_carry, 0);
        chk("add1_mis", if1.rsp_mismatch, 0);
        tick(1);
        chk("add1_ready_back", if1.in_ready, 1);
        issue(0, 4'd15, 4'd1, 2'b00, lat);
        chk("add2_res", if1.rsp_result, 4'd0);
        chk("add2_c", if1.rsp_carry, 1);
        chk("add2_mis", if1.rsp_mismatch, 0);
        chk("add2_opc", op1, 2);
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;

        issue(0, 4'd6, 4'd3, 2'b01, lat);
        chk("sub1_res", if1.rsp_result, 4'd3);
        chk("sub1_c", if1.rsp_carry, 0);
        tick(1);
        issue(0, 4'd2, 4'd4, 2'b01, lat);
        chk("sub2_res", if1.rsp_result, 4'd14);
        chk("sub2_c", if1.rsp_carry, 1);
        chk("sub2_expc", if1.rsp_exp_carry, 1);
        tick(1);
        issue(0, 4'b1010, 4'b1100, 2'b10, lat);
        chk("and_res", if1.rsp_result, 4'b1000);
        chk("and_c", if1.rsp_carry, 0);
        tick(1);
        issue(0, 4'b1010, 4'b1100, 2'b11, lat);
        chk("or_res", if1.rsp_result, 4'b1110);
        chk("or_c", if1.rsp_carry, 0);
        chk("grp_opc", op1, 4);
        chk("grp_errc", er1, 0);
        chk("grp_flag", fl1, 0);
        tick(1);

        f1 = 1'b1;
        issue(0, 4'd3, 4'd5, 2'b00, lat);
        chk("flt_res", if1.rsp_result, 4'd9);
        chk("flt_exp", if1.rsp_exp_result, 4'd8);
        chk("flt_mis", if1.rsp_mismatch, 1);
        chk("flt_errc", er1, 1);
        chk("flt_flag", fl1, 1);
        tick(1);
        f1 = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_opc", op1, 0);
        chk("clr_errc", er1, 0);
        chk("clr_flag", fl1, 0);

        rr = 1'b0;
        issue(0, 4'd1, 4'd1, 2'b00, lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", if1.rsp_valid, 1);
            chk("bp_res", if1.rsp_result, 4'd2);
            chk("bp_ready", if1.in_ready, 0);
            tick(1);
        end
        rr = 1'b1;
        tick(1);
        chk("bp_done_valid", if1.rsp_valid, 0);
        chk("bp_done_ready", if1.in_ready, 1);
        chk("hold_alu_a", a1, 4'd1);

        issue(1, 4'd7, 4'd2, 2'b01, lat);
        chk("s3_lat", lat, 3);
        chk("s3_res", if3.rsp_result, 4'd5);
        tick(1);
        a_r = 4'd4;
        b_r = 4'd4;
        s_r = 2'b00;
        vld[1] = 1'b1;
        tick(1);
        vld[1] = 1'b0;
        tick(1);
        chk("s3_midop_alu_a", a3, 4'd4);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", if3.in_ready, 0);
        chk("mrst_valid", if3.rsp_valid, 0);
        chk("mrst_alu_a", a3, 0);
        chk("mrst_opc", op3, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("mrst_rel_ready", if3.in_ready, 1);
        issue(1, 4'd9, 4'd6, 2'b11, lat);
        chk("post_lat", lat, 3);
        chk("post_res", if3.rsp_result, 4'hF);
        chk("post_mis", if3.rsp_mismatch, 0);
        chk("post_opc", op3, 1);
        tick(1);

        fs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(2, 4'd3, 4'd5, 2'b00, lat);
            chk("sat_mis", ifs.rsp_mismatch, 1);
            tick(1);
        end
        chk("sat_opc", ops, 3);
        chk("sat_errc", ers, 3);
        chk("sat_flag", fls, 1);
        a_r = 4'd3;
        b_r = 4'd5;
        s_r = 2'b00;
        vld[2] = 1'b1;
        tick(1);
        vld[2] = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("cc_valid", ifs.rsp_valid, 1);
        chk("cc_mis", ifs.rsp_mismatch, 1);
        chk("cc_opc", ops, 0);
        chk("cc_errc", ers, 0);
        chk("cc_flag", fls, 0);
        tick(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_checker.md
# alu_checker

Synthesizable self-checking driver for the team's 4-bit `alu`: the initiator/checker end of the ALU's A/B/Sel → Result/Carry interface. It accepts operation commands over a valid/ready handshake, drives the ALU operand ports, and waits a programmable settle time. It then samples Result/Carry, compares them against an internal golden model, returns a response over a second handshake, and keeps pass/fail statistics. It sits between a command source (sequencer, BIST controller, or bench) and an `alu` instance.

## Interface
- `DATA_W`, 4: operand/result width; must match the attached ALU.
- `SETTLE`, 1: cycles the ALU inputs are held before sampling; legal range 1..15.
- `CNT_W`, 8: width of the operation and error counters.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  command ready.
- `in_a`, `in_b`  in  DATA_W  operands.
- `in_sel`  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `alu_a`, `alu_b`  out  DATA_W  registered drive to ALU `A`/`B`.
- `alu_sel`  out  2  registered drive to ALU `Sel`.
- `alu_result`  in  DATA_W  ALU `Result`.
- `alu_carry`  in  1  ALU `Carry`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response ready.
- `rsp_result`, `rsp_exp_result`  out  DATA_W  sampled and expected result.
- `rsp_carry`, `rsp_exp_carry`  out  1  sampled and expected carry.
- `rsp_mismatch`  out  1  sampled ≠ expected (either field).
- `clear`  in  1  synchronous clear of statistics.
- `op_count`, `err_count`  out  CNT_W  completed ops / mismatching ops, saturating.
- `err_flag`  out  1  sticky: any mismatch since reset/clear.

## Operation
- **Golden model, (DATA_W+1)-bit arithmetic:**
  - ADD: {carry,result} = A + B.
  - SUB: {carry,result} = {0,A} − {0,B}, so carry = borrow (1 when A < B).
  - AND: result = A & B, carry = 0.
  - OR: result = A | B, carry = 0.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: `in_ready` = 1. On `in_valid`: latch operands into `alu_*`, compute and latch expected values, load settle counter with SETTLE−1, go to WAIT.
  - WAIT: `in_ready` = 0; `alu_*` held stable. While counter > 0, decrement. At counter = 0, on that edge: capture `alu_result`/`alu_carry`, set `rsp_mismatch`, set `rsp_valid`, go to RESP.
  - RESP: all `rsp_*` held stable while `rsp_valid` & !`rsp_ready`. On handshake: clear `rsp_valid`, go to IDLE.
- **Statistics:** `op_count` increments by 1 on the capture edge. `err_count` increments on the capture edge if mismatch. Both saturate at all-ones. `err_flag` sets on any capture mismatch.
- **`clear`:** zeroes `op_count`, `err_count`, `err_flag`. `clear` has priority over an increment in the same cycle. The response from that op is still delivered with its true `rsp_mismatch`.
- **`alu_*` after completion:** keep their last values after the op completes; they change only at command acceptance.
- **Reset (asynchronous, any state including mid-op):**
  - State → IDLE.
  - `alu_a`, `alu_b`, `alu_sel`, all `rsp_*`, counters, and `err_flag` → 0.
  - `in_ready` = 0 while `rst` high, 1 the first cycle after release.
  - An in-flight op is dropped and not counted.

## Timing
- Command accepted at edge T0 (`in_valid` & `in_ready`). `alu_*` show new operands from T0.
- Capture occurs at edge T0+SETTLE. `rsp_valid` is high from T0+SETTLE until its handshake.
- Response handshake at edge Tr; the next command can be accepted no earlier than edge Tr+1. `in_ready` is not asserted during RESP, including the handshake cycle.
- Minimum spacing between accepts: SETTLE+2 cycles with `rsp_ready` tied high.
- Counters and `err_flag` update at the capture edge and are visible the same cycle `rsp_valid` rises.

## Test plan
- **ADD, correct ALU, SETTLE=1:** 3+5 → rsp_result 8, carry 0, mismatch 0. 15+1 → result 0, carry 1, mismatch 0. `rsp_valid` 1 cycle after accept.
- **SUB/AND/OR, correct ALU:**
  - 6−3 → 3, carry 0.
  - 2−4 → 14, carry 1.
  - 1010 & 1100 → 1000, carry 0.
  - 1010 | 1100 → 1110, carry 0.
  - op_count = 4, err_count = 0, err_flag = 0.
- **Fault injection (ALU Result bit 0 stuck at 1):** 3+5 → rsp_result 9, exp 8, mismatch 1, err_count 1, err_flag 1. Then `clear` → counters 0, flag 0.
- **Backpressure:** `rsp_ready` low for 5 cycles after `rsp_valid` → `rsp_*` stable throughout, `in_ready` stays 0. Handshake → `in_ready` 1 on the next cycle.
- **SETTLE=3 and reset mid-op:** check latency is 3 cycles. Assert `rst` while in WAIT → all outputs 0 immediately, op_count unchanged at 0. Next op after release completes normally.
- **Saturation (CNT_W=2, faulty ALU):** 5 failing ops → op_count and err_count stay at 3. `clear` coinciding with a capture edge → counters 0 and that response still shows mismatch 1.
